// File: rtl/imm_pkg.sv
// Shared definitions for the ARMv8 immediate-extension pipeline:
// the decoded format enum and the opcode mask/match pairs used to
// classify an instruction word.
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_B     = 3'd1,
    FMT_CB    = 3'd2,
    FMT_BCOND = 3'd3,
    FMT_D     = 3'd4,
    FMT_I     = 3'd5,
    FMT_IW    = 3'd6
  } imm_fmt_e;

  // B/BL: instr[30:26] = 00101
  localparam logic [31:0] B_MASK      = 32'h7C00_0000;
  localparam logic [31:0] B_MATCH     = 32'h1400_0000;
  // CBZ/CBNZ: instr[30:25] = 011010
  localparam logic [31:0] CB_MASK     = 32'h7E00_0000;
  localparam logic [31:0] CB_MATCH    = 32'h3400_0000;
  // B.cond: instr[31:24] = 0x54
  localparam logic [31:0] BCOND_MASK  = 32'hFF00_0000;
  localparam logic [31:0] BCOND_MATCH = 32'h5400_0000;
  // Load/store unscaled: instr[29:27] = 111, instr[24] = 0, instr[21] = 0
  localparam logic [31:0] D_MASK      = 32'h3920_0000;
  localparam logic [31:0] D_MATCH     = 32'h3800_0000;
  // Add/sub immediate: instr[28:24] = 10001
  localparam logic [31:0] I_MASK      = 32'h1F00_0000;
  localparam logic [31:0] I_MATCH     = 32'h1100_0000;
  // Move wide: instr[28:23] = 100101
  localparam logic [31:0] IW_MASK     = 32'h1F80_0000;
  localparam logic [31:0] IW_MATCH    = 32'h1280_0000;

  function automatic logic op_match(input logic [31:0] instr,
                                    input logic [31:0] mask,
                                    input logic [31:0] match);
    return (instr & mask) == match;
  endfunction

endpackage

// File: rtl/imm_fmt_decode.sv
// Combinational classifier: maps a 32-bit ARMv8 instruction word to its
// immediate format. Earlier entries in the priority chain win.
module imm_fmt_decode
  import imm_pkg::*;
(
  input  logic [31:0] instr,
  output imm_fmt_e    fmt
);

  // Priority match of the opcode patterns, NONE when nothing matches
  always_comb begin
    fmt = FMT_NONE;
    if (op_match(instr, B_MASK, B_MATCH))
      fmt = FMT_B;
    else if (op_match(instr, CB_MASK, CB_MATCH))
      fmt = FMT_CB;
    else if (op_match(instr, BCOND_MASK, BCOND_MATCH))
      fmt = FMT_BCOND;
    else if (op_match(instr, D_MASK, D_MATCH))
      fmt = FMT_D;
    else if (op_match(instr, I_MASK, I_MATCH))
      fmt = FMT_I;
    else if (op_match(instr, IW_MASK, IW_MATCH))
      fmt = FMT_IW;
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Two-stage immediate extraction/extension pipeline with valid/ready
// handshakes on both sides, flush, and a saturating illegal counter.
// S1 holds the instruction payload and its decoded format; S2 holds the
// extended immediate, format and illegal flag presented to the consumer.
// Build option IMM_BRANCH_SHL2_EN: when defined, B/CB/BCOND offsets are
// returned as byte offsets (shifted left by 2); otherwise as word offsets.
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  function automatic logic signed [XLEN-1:0] sext26(input logic [25:0] f);
    return signed'({{(XLEN-26){f[25]}}, f});
  endfunction

  function automatic logic signed [XLEN-1:0] sext19(input logic [18:0] f);
    return signed'({{(XLEN-19){f[18]}}, f});
  endfunction

  function automatic logic signed [XLEN-1:0] sext9(input logic [8:0] f);
    return signed'({{(XLEN-9){f[8]}}, f});
  endfunction

  function automatic logic signed [XLEN-1:0] zext12(input logic [11:0] f);
    return signed'({{(XLEN-12){1'b0}}, f});
  endfunction

  // Move-wide payload placed in 16-bit lane hw; callers reject lanes
  // that do not exist for the configured XLEN.
  function automatic logic signed [XLEN-1:0] movewide(input logic [15:0] f,
                                                      input logic [1:0]  hw);
    logic [XLEN-1:0] w;
    w = {{(XLEN-16){1'b0}}, f} << {hw, 4'b0000};
    return signed'(w);
  endfunction

  function automatic logic signed [XLEN-1:0] branch_off(input logic signed [XLEN-1:0] v);
`ifdef IMM_BRANCH_SHL2_EN
    return v <<< 2;
`else
    return v;
`endif
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  imm_fmt_e               fmt_dec;

  logic                   vld_p1;
  logic [25:0]            instr_p1;
  imm_fmt_e               fmt_p1;

  logic                   vld_p2;
  logic signed [XLEN-1:0] imm_p2;
  imm_fmt_e               fmt_p2;
  logic                   ill_p2;

  logic [CNT_W-1:0]       cnt_q;

  logic                   adv_p1;
  logic                   s1_open;
  logic                   accept;
  logic signed [XLEN-1:0] imm_nx;
  logic                   ill_nx;

  // S1 can move into S2 whenever S2 is empty or is being drained this cycle;
  // S1 can take a new word when it is empty or moving on.
  assign adv_p1   = !vld_p2 || out_ready;
  assign s1_open  = !vld_p1 || adv_p1;
  assign in_ready = rst_n && !flush && s1_open;
  assign accept   = in_valid && in_ready;

  imm_fmt_decode u_dec (
    .instr (in_instr),
    .fmt   (fmt_dec)
  );

  // ---- S1: input register (instruction payload + decoded format) ----

  // S1 occupancy
  always_ff @(posedge clk) begin
    if (!rst_n)
      vld_p1 <= 1'b0;
    else if (flush)
      vld_p1 <= 1'b0;
    else if (s1_open)
      vld_p1 <= in_valid;
  end

  // S1 payload; only bits [25:0] feed any immediate field
  always_ff @(posedge clk) begin
    if (accept) begin
      instr_p1 <= in_instr[25:0];
      fmt_p1   <= fmt_dec;
    end
  end

  // Field extraction and extension for the entry held in S1
  always_comb begin
    imm_nx = '0;
    ill_nx = 1'b0;
    case (fmt_p1)
      FMT_B:             imm_nx = branch_off(sext26(instr_p1[25:0]));
      FMT_CB, FMT_BCOND: imm_nx = branch_off(sext19(instr_p1[23:5]));
      FMT_D:             imm_nx = sext9(instr_p1[20:12]);
      FMT_I:             imm_nx = zext12(instr_p1[21:10]);
      FMT_IW: begin
        // Lanes 2 and 3 do not exist in a 32-bit datapath
        if (XLEN == 32 && instr_p1[22])
          ill_nx = 1'b1;
        else
          imm_nx = movewide(instr_p1[20:5], instr_p1[22:21]);
      end
      default:           ill_nx = 1'b1;
    endcase
  end

  // ---- S2: output register presented to the consumer ----

  // S2 occupancy
  always_ff @(posedge clk) begin
    if (!rst_n)
      vld_p2 <= 1'b0;
    else if (flush)
      vld_p2 <= 1'b0;
    else if (adv_p1)
      vld_p2 <= vld_p1;
  end

  // S2 result; frozen while the consumer stalls so outputs stay stable
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      imm_p2 <= '0;
      fmt_p2 <= FMT_NONE;
      ill_p2 <= 1'b0;
    end else if (adv_p1 && vld_p1) begin
      imm_p2 <= imm_nx;
      fmt_p2 <= fmt_p1;
      ill_p2 <= ill_nx;
    end
  end

  // Saturating count of illegal results actually handed to the consumer
  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (vld_p2 && out_ready && ill_p2)
      cnt_q <= sat_inc(cnt_q);
  end

  assign out_valid   = vld_p2;
  assign out_imm     = imm_p2;
  assign out_fmt     = fmt_p2;
  assign out_illegal = ill_p2;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: a 64-bit/16-bit-counter instance and a
// 32-bit/2-bit-counter instance share all inputs and run in lockstep.
// A scoreboard queue receives the model result at every accepted input
// and is compared against both instances at every output transfer.
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_instr;

  logic        in_ready_a, out_valid_a, out_illegal_a;
  logic [63:0] out_imm_a;
  logic [2:0]  out_fmt_a;
  logic [15:0] cnt_a;

  logic        in_ready_b, out_valid_b, out_illegal_b;
  logic [31:0] out_imm_b;
  logic [2:0]  out_fmt_b;
  logic [1:0]  cnt_b;

  int checks = 0;
  int errors = 0;
  int delivered = 0;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm64;
    logic [2:0]  fmt;
    logic        ill64;
    logic [31:0] imm32;
    logic        ill32;
  } exp_t;

  exp_t sbq[$];

  always #5 clk = ~clk;

  imm_extend_pipe #(.XLEN(64), .CNT_W(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_instr(in_instr),
    .out_valid(out_valid_a), .out_ready(out_ready),
    .out_imm(out_imm_a), .out_fmt(out_fmt_a), .out_illegal(out_illegal_a),
    .illegal_cnt(cnt_a)
  );

  imm_extend_pipe #(.XLEN(32), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_instr(in_instr),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_imm(out_imm_b), .out_fmt(out_fmt_b), .out_illegal(out_illegal_b),
    .illegal_cnt(cnt_b)
  );

`ifdef IMM_BRANCH_SHL2_EN
  localparam logic [63:0] EXP_B     = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam logic [63:0] EXP_CB    = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam logic [63:0] EXP_BCOND = 64'h0000_0000_0000_0008;
`else
  localparam logic [63:0] EXP_B     = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] EXP_CB    = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] EXP_BCOND = 64'h0000_0000_0000_0002;
`endif

  function automatic longint sx(input longint x, input int n);
    if (x[n-1]) return x - (longint'(1) << n);
    return x;
  endfunction

  // Reference model: field-by-field decode, arithmetic extension
  function automatic exp_t model(input logic [31:0] i);
    exp_t e;
    longint v;
    logic [2:0] f;
    if (i[30:26] == 5'b00101)                              f = 3'd1;
    else if (i[30:25] == 6'b011010)                        f = 3'd2;
    else if (i[31:24] == 8'h54)                            f = 3'd3;
    else if (i[29:27] == 3'b111 && !i[24] && !i[21])       f = 3'd4;
    else if (i[28:24] == 5'b10001)                         f = 3'd5;
    else if (i[28:23] == 6'b100101)                        f = 3'd6;
    else                                                   f = 3'd0;
    case (f)
      3'd1:       v = sx(longint'(i[25:0]), 26);
      3'd2, 3'd3: v = sx(longint'(i[23:5]), 19);
      3'd4:       v = sx(longint'(i[20:12]), 9);
      3'd5:       v = longint'(i[21:10]);
      3'd6:       v = longint'(i[20:5]) * (longint'(1) << (16 * int'(i[22:21])));
      default:    v = 0;
    endcase
`ifdef IMM_BRANCH_SHL2_EN
    if (f == 3'd1 || f == 3'd2 || f == 3'd3) v = v * 4;
`endif
    e.instr = i;
    e.fmt   = f;
    e.imm64 = v;
    e.ill64 = (f == 3'd0);
    e.ill32 = (f == 3'd0) || (f == 3'd6 && i[22]);
    e.imm32 = e.ill32 ? 32'h0 : v[31:0];
    return e;
  endfunction

  // Scoreboard: pop/compare on output transfers, push on input accepts
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sbq.delete();
    end else begin
      checks++;
      if (out_valid_a !== out_valid_b || in_ready_a !== in_ready_b) begin
        errors++;
        $display("FAIL lockstep: valid a/b %b/%b ready a/b %b/%b",
                 out_valid_a, out_valid_b, in_ready_a, in_ready_b);
      end
      if (out_valid_a && out_ready) begin
        delivered++;
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected: output imm %h with no pending entry", out_imm_a);
        end else begin
          e = sbq.pop_front();
          if (out_imm_a !== e.imm64 || out_fmt_a !== e.fmt || out_illegal_a !== e.ill64) begin
            errors++;
            $display("FAIL sb_x64 instr %h: got imm %h fmt %0d ill %b, want imm %h fmt %0d ill %b",
                     e.instr, out_imm_a, out_fmt_a, out_illegal_a, e.imm64, e.fmt, e.ill64);
          end
          checks++;
          if (out_imm_b !== e.imm32 || out_fmt_b !== e.fmt || out_illegal_b !== e.ill32) begin
            errors++;
            $display("FAIL sb_x32 instr %h: got imm %h fmt %0d ill %b, want imm %h fmt %0d ill %b",
                     e.instr, out_imm_b, out_fmt_b, out_illegal_b, e.imm32, e.fmt, e.ill32);
          end
        end
      end
      if (flush)
        sbq.delete();
      else if (in_valid && in_ready_a)
        sbq.push_back(model(in_instr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    in_instr = 32'h17FF_FFFF;
    tick();
    tick();
    checks++;
    if (in_ready_a !== 1'b0 || in_ready_b !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready: got %b/%b want 0", in_ready_a, in_ready_b);
    end
    checks++;
    if (out_valid_a !== 1'b0 || out_imm_a !== 64'h0 || out_fmt_a !== 3'd0 || out_illegal_a !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: valid %b imm %h fmt %0d ill %b want all 0",
                         out_valid_a, out_imm_a, out_fmt_a, out_illegal_a);
    end
    checks++;
    if (cnt_a !== 16'h0 || cnt_b !== 2'h0) begin
      errors++; $display("FAIL reset_cnt: got %0d/%0d want 0", cnt_a, cnt_b);
    end
    rst_n = 1'b1; in_valid = 1'b0;
    tick();
  endtask

  task automatic test_formats();
    logic [31:0] vi [6];
    logic [63:0] vimm [6];
    logic [2:0]  vfmt [6];
    vi[0] = 32'h17FF_FFFF; vimm[0] = EXP_B;                 vfmt[0] = 3'd1;
    vi[1] = 32'hB4FF_FFE0; vimm[1] = EXP_CB;                vfmt[1] = 3'd2;
    vi[2] = 32'h5400_0040; vimm[2] = EXP_BCOND;             vfmt[2] = 3'd3;
    vi[3] = 32'hF85F_83E0; vimm[3] = 64'hFFFF_FFFF_FFFF_FFF8; vfmt[3] = 3'd4;
    vi[4] = 32'h913F_FC21; vimm[4] = 64'h0000_0000_0000_0FFF; vfmt[4] = 3'd5;
    vi[5] = 32'hD2E2_4680; vimm[5] = 64'h1234_0000_0000_0000; vfmt[5] = 3'd6;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1; in_instr = vi[k];
      tick();
      in_valid = 1'b0;
      checks++;
      if (out_valid_a !== 1'b0) begin
        errors++; $display("FAIL latency_early %h: out_valid %b want 0", vi[k], out_valid_a);
      end
      tick();
      checks++;
      if (out_valid_a !== 1'b1 || out_imm_a !== vimm[k] || out_fmt_a !== vfmt[k] || out_illegal_a !== 1'b0) begin
        errors++; $display("FAIL fmt64 %h: valid %b imm %h fmt %0d ill %b want 1 %h %0d 0",
                           vi[k], out_valid_a, out_imm_a, out_fmt_a, out_illegal_a, vimm[k], vfmt[k]);
      end
      checks++;
      if (k == 5) begin
        if (out_imm_b !== 32'h0 || out_illegal_b !== 1'b1 || out_fmt_b !== 3'd6) begin
          errors++; $display("FAIL movz32: imm %h ill %b fmt %0d want 0 1 6",
                             out_imm_b, out_illegal_b, out_fmt_b);
        end
      end else if (out_imm_b !== vimm[k][31:0] || out_illegal_b !== 1'b0) begin
        errors++; $display("FAIL fmt32 %h: imm %h ill %b want %h 0",
                           vi[k], out_imm_b, out_illegal_b, vimm[k][31:0]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    int base;
    base = delivered;
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h913F_FC21;
    tick();
    in_instr = 32'hF85F_83E0;
    tick();
    in_instr = 32'h17FF_FFFF;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (in_ready_a !== 1'b0) begin
        errors++; $display("FAIL bp_in_ready cycle %0d: got %b want 0", k, in_ready_a);
      end
      checks++;
      if (out_valid_a !== 1'b1 || out_imm_a !== 64'h0000_0000_0000_0FFF) begin
        errors++; $display("FAIL bp_hold cycle %0d: valid %b imm %h want 1 fff", k, out_valid_a, out_imm_a);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 10 && sbq.size() != 0; k++) tick();
    tick();
    checks++;
    if (delivered - base !== 3 || sbq.size() != 0) begin
      errors++; $display("FAIL bp_drain: delivered %0d want 3, pending %0d", delivered - base, sbq.size());
    end
    checks++;
    if (out_valid_a !== 1'b0) begin
      errors++; $display("FAIL bp_idle: out_valid %b want 0", out_valid_a);
    end
  endtask

  task automatic test_mid_reset();
    int base;
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'h913F_FC21;
    tick();
    in_valid = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    base = delivered;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (out_valid_a !== 1'b0) begin
        errors++; $display("FAIL midreset_valid cycle %0d: got %b want 0", k, out_valid_a);
      end
      tick();
    end
    checks++;
    if (delivered !== base) begin
      errors++; $display("FAIL midreset_emit: delivered %0d want %0d", delivered, base);
    end
  endtask

  task automatic test_random();
    logic [31:0] r;
    for (int n = 0; n < 300; n++) begin
      r = $urandom;
      case ($urandom_range(0, 6))
        0: r[30:26] = 5'b00101;
        1: r[30:25] = 6'b011010;
        2: r[31:24] = 8'h54;
        3: begin r[29:27] = 3'b111; r[24] = 1'b0; r[21] = 1'b0; end
        4: r[28:24] = 5'b10001;
        5: r[28:23] = 6'b100101;
        default: ;
      endcase
      in_instr  = r;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 20 && sbq.size() != 0; k++) tick();
    tick();
    checks++;
    if (sbq.size() != 0 || out_valid_a !== 1'b0) begin
      errors++; $display("FAIL random_drain: pending %0d valid %b want 0 0", sbq.size(), out_valid_a);
    end
  endtask

  task automatic test_illegal_flush();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    in_instr = 32'h0000_0000;
    in_valid = 1'b1;
    tick(); tick(); tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (cnt_a !== 16'd3 || cnt_b !== 2'd3) begin
      errors++; $display("FAIL illegal_cnt3: got %0d/%0d want 3/3", cnt_a, cnt_b);
    end
    out_ready = 1'b0;
    in_valid = 1'b1;
    tick(); tick();
    in_valid = 1'b0; flush = 1'b1;
    checks++;
    if (in_ready_a !== 1'b0 || out_valid_a !== 1'b1) begin
      errors++; $display("FAIL flush_cycle: in_ready %b out_valid %b want 0 1", in_ready_a, out_valid_a);
    end
    tick();
    flush = 1'b0;
    checks++;
    if (out_valid_a !== 1'b0 || cnt_a !== 16'd3) begin
      errors++; $display("FAIL flush_after: out_valid %b cnt %0d want 0 3", out_valid_a, cnt_a);
    end
    out_ready = 1'b1;
    tick(); tick();
    checks++;
    if (out_valid_a !== 1'b0) begin
      errors++; $display("FAIL flush_no_ghost: out_valid %b want 0", out_valid_a);
    end
    in_valid = 1'b1;
    tick(); tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (cnt_a !== 16'd5) begin
      errors++; $display("FAIL illegal_cnt5: got %0d want 5", cnt_a);
    end
    checks++;
    if (cnt_b !== 2'd3) begin
      errors++; $display("FAIL illegal_cnt_sat: got %0d want 3", cnt_b);
    end
  endtask

  initial begin
    test_reset();
    test_formats();
    test_back_to_back();
    test_mid_reset();
    test_random();
    test_illegal_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 Parameter XLEN, default 64, output datapath width; legal values 32 and 64 only.
REQ-002 Parameter CNT_W, default 16, width of the illegal-encoding counter.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 flush  input  1  drops all in-flight entries.
REQ-006 in_valid  input  1  in_instr is valid.
REQ-007 in_ready  output  1  block accepts in_instr this cycle.
REQ-008 in_instr  input  32  ARMv8 instruction word.
REQ-009 out_valid  output  1  out_* fields are valid.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 out_imm  output  XLEN  extended immediate.
REQ-012 out_fmt  output  3  decoded format: 0 NONE, 1 B, 2 CB, 3 BCOND, 4 D, 5 I, 6 IW.
REQ-013 out_illegal  output  1  no immediate format matched, or encoding illegal for XLEN.
REQ-014 illegal_cnt  output  CNT_W  saturating count of illegal results delivered.

Function
REQ-015 Two-stage pipeline: S1 registers instr and format; S2 registers out_imm, out_fmt and out_illegal.
- Latency is 2 cycles from in accept to out_valid when out_ready is held high.
- Throughput is 1 per cycle.
REQ-016 Handshakes:
- Input transfer occurs on in_valid and in_ready.
- Output transfer occurs on out_valid and out_ready.
- in_ready = !S1.valid or S1 advances.
- S1 advances when !S2.valid or out_ready.
- A combinational path from out_ready to in_ready is permitted.
REQ-017 While out_valid is high and out_ready is low, out_imm, out_fmt and out_illegal SHALL hold stable; no entry is lost or duplicated.
REQ-018 Format decode, first match wins:
- B/BL: instr[30:26]=00101.
- CB: instr[30:25]=011010.
- BCOND: instr[31:24]=0x54.
- D: instr[29:27]=111, instr[24]=0, instr[21]=0.
- I: instr[28:24]=10001.
- IW: instr[28:23]=100101.
- Otherwise NONE.
REQ-019 Extension per format:
- B: sign-extend instr[25:0].
- CB and BCOND: sign-extend instr[23:5].
- D: sign-extend instr[20:12].
- I: zero-extend instr[21:10].
- IW: zero-extend instr[20:5], then shift left by 16*instr[22:21].
REQ-020 NONE SHALL give out_imm=0 and out_illegal=1.
REQ-021 If XLEN=32 and IW has instr[22]=1, the result SHALL be out_imm=0, out_illegal=1, out_fmt=IW.
REQ-022 illegal_cnt SHALL increment by 1 on each output transfer with out_illegal=1, saturating at all-ones.
REQ-023 flush SHALL clear S1.valid and S2.valid next cycle.
- flush wins over a simultaneous input accept.
- illegal_cnt is unaffected by flush.
- in_ready SHALL be 0 during the flush cycle.

Reset
REQ-024 With rst_n low at a clock edge, next state SHALL be: S1/S2 valid=0, out_imm=0, out_fmt=0, out_illegal=0, illegal_cnt=0.
REQ-025 Reset asserted mid-operation SHALL discard all in-flight entries without emitting them.
REQ-026 in_ready SHALL be 0 while rst_n is low.

Configuration
REQ-027 Macro IMM_BRANCH_SHL2_EN:
- Defined: B, CB and BCOND results are shifted left by 2 after sign extension (byte offsets).
- Undefined: they are word offsets, unshifted.
- D, I and IW are unaffected either way.

Structure
REQ-028 Shared package imm_pkg SHALL hold:
- the imm_fmt_e enum (3-bit, values per REQ-012);
- the opcode match constants of REQ-018.
REQ-029 Sub-module imm_fmt_decode: combinational, instr to imm_fmt_e; instantiated in S1.

Verification
REQ-030 B, 0x17FFFFFF -> out_imm 0xFFFFFFFFFFFFFFFF, fmt 1, 2 cycles later; with IMM_BRANCH_SHL2_EN -> 0xFFFFFFFFFFFFFFFC.
REQ-031 LDUR 0xF85F83E0 -> out_imm 0xFFFFFFFFFFFFFFF8, fmt 4; ADDI 0x913FFC21 -> 0x0000000000000FFF, fmt 5.
REQ-032 MOVZ 0xD2E24680:
- XLEN=64 -> 0x1234000000000000, fmt 6, out_illegal 0.
- XLEN=32 -> out_imm 0, out_illegal 1.
REQ-033 Backpressure:
- Three back-to-back inputs, out_ready low for 4 cycles.
- in_ready drops after 2 accepts; out_imm held stable.
- After release, all 3 results emerge in order.
REQ-034 Illegal and flush:
- 0x00000000 x3 -> out_illegal 1 each, illegal_cnt 3.
- flush with 2 entries in flight -> out_valid 0 next cycle, illegal_cnt unchanged.
- CNT_W=2, 5 illegal results -> illegal_cnt saturates at 3.
